// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver with sticky rdy; stop-bit framing check when UART_RX_FRM_ERR_EN is defined
module uart_rx #(
    parameter int BAUD_DIV = 2604
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RX,
    input  logic       clr_rdy,
    output logic [7:0] rx_data,
    output logic       rdy,
    output logic       frm_err
);
    localparam int CW = $clog2(BAUD_DIV);
    typedef enum logic {IDLE, RECEIVE} state_t;
    state_t        state;
    logic [CW-1:0] baud;
    logic [3:0]    bits;
    logic [8:0]    shift, shift_n;
    logic          s1, s2, s3, start, strobe, done;
    assign start   = state == IDLE && s3 && !s2;
    assign strobe  = state == RECEIVE && baud == '0;
    assign done    = strobe && bits == 4'd9;
    assign shift_n = {s2, shift[8:1]};
`ifndef UART_RX_FRM_ERR_EN
    assign frm_err = 1'b0;
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {s3, s2, s1} <= 3'b111;
            state        <= IDLE;
            baud         <= '0;
            bits         <= '0;
            shift        <= 9'h1FF;
            rx_data      <= '0;
            rdy          <= 1'b0;
`ifdef UART_RX_FRM_ERR_EN
            frm_err      <= 1'b0;
`endif
        end else begin
            {s3, s2, s1} <= {s2, s1, RX};
            if (done) begin
                rdy     <= 1'b1;
                rx_data <= shift_n[7:0];
            end else if (clr_rdy || start)
                rdy <= 1'b0;
`ifdef UART_RX_FRM_ERR_EN
            if (done)
                frm_err <= ~s2;
            else if (clr_rdy || start)
                frm_err <= 1'b0;
`endif
            if (state == IDLE) begin
                if (start) begin
                    state <= RECEIVE;
                    baud  <= CW'(BAUD_DIV / 2);
                    bits  <= '0;
                end
            end else if (!strobe)
                baud <= baud - 1'b1;
            else begin
                baud <= CW'(BAUD_DIV - 1);
                bits <= bits + 4'd1;
                if (bits != 4'd0)
                    shift <= shift_n;
                // a high start-bit centre is a glitch, not a frame
                if ((bits == 4'd0 && s2) || bits == 4'd9)
                    state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed checks of uart_rx at a short baud divisor
module tb_uart_rx;
    localparam int B = 32;
    localparam int LAT = B / 2 + 9 * B + 4;
`ifdef UART_RX_FRM_ERR_EN
    localparam logic FE_EXP = 1'b1;
`else
    localparam logic FE_EXP = 1'b0;
`endif
    logic       clk = 0, rst = 1, RX = 1, clr_rdy = 0;
    logic [7:0] rx_data;
    logic       rdy, frm_err;
    int         checks = 0, errors = 0;

    uart_rx #(.BAUD_DIV(B)) dut (
        .clk(clk), .rst(rst), .RX(RX), .clr_rdy(clr_rdy),
        .rx_data(rx_data), .rdy(rdy), .frm_err(frm_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] d, input logic stop);
        RX = 0;
        tick(B);
        for (int i = 0; i < 8; i++) begin
            RX = d[i];
            tick(B);
        end
        RX = stop;
        tick(B);
        RX = 1;
    endtask

    task automatic pulse_clr();
        clr_rdy = 1;
        tick(1);
        clr_rdy = 0;
    endtask

    task automatic test_reset();
        tick(3);
        checks += 3;
        if (rdy !== 1'b0) begin errors++; $display("FAIL reset_rdy got %b exp 0", rdy); end
        if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", rx_data); end
        if (frm_err !== 1'b0) begin errors++; $display("FAIL reset_frm got %b exp 0", frm_err); end
        rst = 0;
        tick(5);
    endtask

    task automatic test_frame();
        int cnt;
        cnt = 0;
        fork
            send(8'hA5, 1'b1);
            while (rdy !== 1'b1 && cnt < 1000) begin
                @(posedge clk);
                #1;
                cnt++;
            end
        join
        checks += 3;
        if (cnt < LAT - 2 || cnt > LAT + 2) begin errors++; $display("FAIL frame_latency got %0d exp %0d", cnt, LAT); end
        if (rx_data !== 8'hA5) begin errors++; $display("FAIL frame_data got %h exp a5", rx_data); end
        if (frm_err !== 1'b0) begin errors++; $display("FAIL frame_frm got %b exp 0", frm_err); end
        tick(4);
    endtask

    task automatic test_clear();
        checks += 3;
        if (rdy !== 1'b1) begin errors++; $display("FAIL clear_pre_rdy got %b exp 1", rdy); end
        pulse_clr();
        if (rdy !== 1'b0) begin errors++; $display("FAIL clear_rdy got %b exp 0", rdy); end
        if (rx_data !== 8'hA5) begin errors++; $display("FAIL clear_data got %h exp a5", rx_data); end
    endtask

    task automatic test_false_start();
        RX = 0;
        tick(6);
        RX = 1;
        tick(12 * B);
        checks += 3;
        if (rdy !== 1'b0) begin errors++; $display("FAIL false_rdy got %b exp 0", rdy); end
        send(8'h3C, 1'b1);
        tick(2);
        if (rdy !== 1'b1) begin errors++; $display("FAIL false_next_rdy got %b exp 1", rdy); end
        if (rx_data !== 8'h3C) begin errors++; $display("FAIL false_next_data got %h exp 3c", rx_data); end
        pulse_clr();
    endtask

    task automatic test_back_to_back();
        send(8'h00, 1'b1);
        checks += 2;
        if (rdy !== 1'b1) begin errors++; $display("FAIL b2b_first_rdy got %b exp 1", rdy); end
        if (rx_data !== 8'h00) begin errors++; $display("FAIL b2b_first_data got %h exp 00", rx_data); end
        fork
            send(8'hFF, 1'b1);
            begin
                tick(4);
                checks += 2;
                if (rdy !== 1'b0) begin errors++; $display("FAIL b2b_drop_rdy got %b exp 0", rdy); end
                if (rx_data !== 8'h00) begin errors++; $display("FAIL b2b_hold_data got %h exp 00", rx_data); end
            end
        join
        tick(2);
        checks += 2;
        if (rdy !== 1'b1) begin errors++; $display("FAIL b2b_second_rdy got %b exp 1", rdy); end
        if (rx_data !== 8'hFF) begin errors++; $display("FAIL b2b_second_data got %h exp ff", rx_data); end
    endtask

    task automatic test_reset_mid();
        fork
            send(8'h5A, 1'b1);
            begin
                tick(5 * B + B / 2);
                rst = 1;
                #1;
                checks += 2;
                if (rdy !== 1'b0) begin errors++; $display("FAIL rstmid_rdy got %b exp 0", rdy); end
                if (rx_data !== 8'h00) begin errors++; $display("FAIL rstmid_data got %h exp 00", rx_data); end
            end
        join
        tick(2);
        rst = 0;
        tick(5);
        send(8'h81, 1'b1);
        tick(2);
        checks += 2;
        if (rdy !== 1'b1) begin errors++; $display("FAIL rstmid_next_rdy got %b exp 1", rdy); end
        if (rx_data !== 8'h81) begin errors++; $display("FAIL rstmid_next_data got %h exp 81", rx_data); end
        pulse_clr();
    endtask

    task automatic test_frm_err();
        send(8'h42, 1'b0);
        tick(2);
        checks += 5;
        if (rdy !== 1'b1) begin errors++; $display("FAIL frm_rdy got %b exp 1", rdy); end
        if (rx_data !== 8'h42) begin errors++; $display("FAIL frm_data got %h exp 42", rx_data); end
        if (frm_err !== FE_EXP) begin errors++; $display("FAIL frm_flag got %b exp %b", frm_err, FE_EXP); end
        pulse_clr();
        if (rdy !== 1'b0) begin errors++; $display("FAIL frm_clr_rdy got %b exp 0", rdy); end
        if (frm_err !== 1'b0) begin errors++; $display("FAIL frm_clr_flag got %b exp 0", frm_err); end
    endtask

    initial begin
        #1;
        test_reset();
        test_frame();
        test_clear();
        test_false_start();
        test_back_to_back();
        test_reset_mid();
        test_frm_err();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver for the 8N1 serial link: samples the asynchronous `RX` line, reassembles one byte per frame and presents it with a sticky ready flag until the consumer clears it. It is the receive end of the design's UART transmitter. It runs on the system clock and shares its baud divisor (2604 cycles per bit, 19200 baud at 50 MHz). Typical clients are a command decoder or a host-interface wrapper.

## Interface
- `BAUD_DIV`, default 2604: clock cycles per bit; must be even and at least 16.
- `clk` input 1: system clock; all state updates on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `RX` input 1: serial line, asynchronous to `clk`, idle high.
- `clr_rdy` input 1: single-cycle pulse; consumer has taken `rx_data`.
- `rx_data` output 8: last received byte, LSB received first.
- `rdy` output 1: sticky; a new byte is valid in `rx_data`.
- `frm_err` output 1: stop bit of the byte in `rx_data` sampled low (see Configuration).

## Operation
- Metastability handling:
  - `RX` passes through two flops, then a third flop for edge detect. All three reset to 1.
  - A start edge is the synchronized value going 1→0.
  - The FSM uses only the synchronized value.
- States and transitions:
  - IDLE: on start edge, load the baud counter with `BAUD_DIV/2`, clear the bit counter, go to RECEIVE.
  - RECEIVE: the baud counter decrements every cycle. When it reaches 0, the sample strobe asserts for 1 cycle, the counter reloads `BAUD_DIV - 1`, and the bit counter increments.
- Sampling:
  - Sample 1 (start-bit centre): if it reads 1, this is a false start. Return to IDLE, with no change to `rdy` or `rx_data`.
  - Samples 2–9: shift into a 9-bit shift register from the MSB end, right shift, LSB-first.
  - Sample 10: stop bit, shifted in the same way.
  - After sample 10, `rx_data` ← shift[7:0], `rdy` set, state returns to IDLE.
- `rdy` is an SR flop:
  - Cleared by `clr_rdy` or by a start edge detected in IDLE.
  - Set on completion.
  - If set and clear occur in the same cycle, set wins.
- `rx_data` holds its value until the next completed frame; it is not cleared on start.
- Bit counter is 4 bits and never wraps: RECEIVE exits at count 10.
- A start edge while in RECEIVE is ignored (edge detect is only qualified in IDLE).

## Timing
- Reset values: `rdy`=0, `frm_err`=0, `rx_data`=0x00, state IDLE, sync flops 1, shift register 0x1FF.
- Start edge detection lags the pin falling edge by 3 clock cycles.
- Sample 1 occurs `BAUD_DIV/2` cycles after detection. Samples 2..10 follow every `BAUD_DIV` cycles.
- `rdy` rises on the cycle after sample 10. That is `BAUD_DIV/2 + 9·BAUD_DIV + 4` cycles (= 24742 at default) after the pin falling edge of the start bit; the bench tolerance is ±2 cycles.
- Earliest next start detection: the stop-bit sample is at mid-stop, so back-to-back frames with no idle gap must be received.
- `clr_rdy` takes effect on the next clock edge (`rdy` low the following cycle).
- Reset asserted mid-frame:
  - Immediately returns all outputs and state to reset values.
  - After release, the line must be high for at least 3 cycles before a start edge is recognised.
  - A partially received frame is discarded.

## Configuration
- `UART_RX_FRM_ERR_EN`:
  - Defined: the stop-bit sample is checked. `frm_err` is loaded with the inverted stop sample when `rdy` is set, and cleared together with `rdy` (by `clr_rdy` or a start edge). `rdy` still asserts on a framing error.
  - Not defined: `frm_err` is tied to 0, the stop sample is discarded, and no checking logic is synthesized.

## Test plan
- Reset, then drive frame 0xA5 at `BAUD_DIV`=2604 → `rdy`=1 at 24742±2 cycles after the start edge, `rx_data`=0xA5, `frm_err`=0.
- With `rdy`=1, pulse `clr_rdy` → `rdy`=0 next cycle, `rx_data` stays 0xA5.
- Drive `RX` low for 500 cycles, then high → no `rdy`, FSM back in IDLE; a following frame 0x3C → `rx_data`=0x3C.
- Send 0x00 then 0xFF back-to-back with no idle gap, never pulsing `clr_rdy` → `rdy` drops at the second start edge and reasserts; `rx_data`=0x00 then 0xFF.
- Assert `rst` mid-frame at bit 4 of 0x5A → `rdy`=0, `rx_data`=0x00 immediately. After release, frame 0x81 is received correctly.
- With `UART_RX_FRM_ERR_EN` defined, send 0x42 with stop bit 0 → `rdy`=1, `rx_data`=0x42, `frm_err`=1. Pulse `clr_rdy` → both 0. Without the macro, the same stimulus gives `frm_err`=0.
